// File: rtl/uart_rx_deframer_if.sv
// Register-side bus of the UART receiver: read/clear strobes in, FIFO head and status out.
interface uart_rx_deframer_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                 rd;
  logic                 clr_err;
  logic [DATA_BITS-1:0] rxdata;
  logic                 rxvalid;
  logic [CntW-1:0]      count;
  logic                 frame_err;
  logic                 overrun;
  logic                 rxint;

  modport master (
    output rd, clr_err,
    input  rxdata, rxvalid, count, frame_err, overrun, rxint
  );

  modport slave (
    input  rd, clr_err,
    output rxdata, rxvalid, count, frame_err, overrun, rxint
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 receive deframer: oversampled start/data/stop detection feeding a small receive FIFO
// with sticky frame-error and overrun flags.
module uart_rx_deframer #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              baud_tick,
  input  logic              rx,
  uart_rx_deframer_if.slave bus
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [TickW-1:0] MidTick  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] LastTick = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);
  localparam logic [CntW-1:0]  Full     = CntW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic                 rx_meta_q, rx_s_q;
  state_e               state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push, fe_set;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [DATA_BITS-1:0] rxdata_q, rxdata_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 pop, push_ok, ovr_set;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else if (baud_tick) begin
      unique case (state_q)
        StIdle:  if (!rx_s_q) state_d = StStart;
        StStart: if (tick_cnt_q == MidTick) state_d = rx_s_q ? StIdle : StData;
        StData:  if (tick_cnt_q == LastTick && bit_cnt_q == LastBit) state_d = StStop;
        StStop:  if (tick_cnt_q == LastTick) state_d = rx_s_q ? StIdle : StBreak;
        StBreak: if (rx_s_q) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push       = 1'b0;
    fe_set     = 1'b0;
    if (!en) begin
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = '0;
    end else if (baud_tick) begin
      unique case (state_q)
        StIdle: begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
        StStart: tick_cnt_d = (tick_cnt_q == MidTick) ? '0 : tick_cnt_q + 1'b1;
        StData: begin
          if (tick_cnt_q == LastTick) begin
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            // LSB first: new bit enters at the top and walks down.
            shift_d    = (shift_q >> 1) | (DATA_BITS'(rx_s_q) << (DATA_BITS - 1));
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (tick_cnt_q == LastTick) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            push       = rx_s_q;
            fe_set     = ~rx_s_q;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pop      = bus.rd && (count_q != '0);
    push_ok  = push && ((count_q != Full) || pop);
    ovr_set  = push && (count_q == Full) && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CntW'(push_ok) - CntW'(pop);
    // Head comes from the write port when the new head slot is being written this cycle.
    if (count_d == '0) begin
      rxdata_d = '0;
    end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
      rxdata_d = shift_q;
    end else begin
      rxdata_d = mem_q[rd_ptr_d];
    end
    frame_err_d = fe_set | (frame_err_q & ~bus.clr_err);
    overrun_d   = ovr_set | (overrun_q & ~bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rxdata_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rxdata_q    <= rxdata_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.rxdata    = rxdata_q;
  assign bus.rxvalid   = (count_q != '0);
  assign bus.count     = count_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.rxint     = (count_q != '0) | frame_err_q | overrun_q;

endmodule
